// File: rtl/locked_mult_key_driver_pkg.sv
// Shared widths and FSM encoding for the locked-multiplier key driver.
package locked_mult_key_driver_pkg;
  localparam int KEY_W   = 32;
  localparam int OP_W    = 8;
  localparam int EPOCH_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;
endpackage

// File: rtl/locked_mult_key_driver_key_scan_chain.sv
// Serial key shadow chain with shift counter, commit qualification and
// the snapshot held while a commit waits for the FSM to return to IDLE.
module key_scan_chain #(
  parameter int KEY_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             key_sin_i,
  input  logic             key_shift_i,
  input  logic             key_commit_i,
  input  logic             defer_i,
  input  logic             apply_i,
  output logic             commit_ok_o,
  output logic             commit_err_o,
  output logic             pending_o,
  output logic [KEY_W-1:0] shadow_o,
  output logic [KEY_W-1:0] snapshot_o
);
  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_W);

  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] snapshot_q, snapshot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;

  // A commit is only trusted once a full key has been shifted and nothing is moving.
  assign commit_ok_o  = key_commit_i && !key_shift_i && (cnt_q == CNT_FULL);
  assign commit_err_o = key_commit_i && !commit_ok_o;

  always_comb begin
    shadow_d   = shadow_q;
    snapshot_d = snapshot_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    if (key_shift_i) begin
      shadow_d = {key_sin_i, shadow_q[KEY_W-1:1]};
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
    end
    if (key_commit_i) cnt_d = '0;
    // A later commit simply overwrites the snapshot; the epoch bump happens once at apply.
    if (apply_i) begin
      pending_d = 1'b0;
    end else if (commit_ok_o && defer_i) begin
      pending_d  = 1'b1;
      snapshot_d = shadow_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q   <= '0;
      snapshot_q <= '0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      snapshot_q <= snapshot_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
    end
  end

  assign pending_o  = pending_q;
  assign shadow_o   = shadow_q;
  assign snapshot_o = snapshot_q;
endmodule

// File: rtl/locked_mult_key_driver.sv
// Drives operands and the active key into a locked multiplier, captures the
// product, and only swaps the key while no multiply is in flight.
module locked_mult_key_driver
  import locked_mult_key_driver_pkg::*;
#(
  parameter int KEY_W = locked_mult_key_driver_pkg::KEY_W,
  parameter int OP_W  = locked_mult_key_driver_pkg::OP_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 key_sin_i,
  input  logic                 key_shift_i,
  input  logic                 key_commit_i,
  output logic                 key_err_o,
  output logic [EPOCH_W-1:0]   key_epoch_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [OP_W-1:0]      op1_req_i,
  input  logic [OP_W-1:0]      op2_req_i,
  output logic [OP_W-1:0]      op1_o,
  output logic [OP_W-1:0]      op2_o,
  output logic [KEY_W-1:0]     keyinput_o,
  input  logic [2*OP_W-1:0]    product_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [2*OP_W-1:0]    rsp_product_o,
  output logic [EPOCH_W-1:0]   rsp_epoch_o
);
  state_e               state_q, state_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 key_err_q, key_err_d;
  logic [OP_W-1:0]      op1_q, op1_d, op2_q, op2_d;
  logic [2*OP_W-1:0]    rsp_product_q, rsp_product_d;
  logic [EPOCH_W-1:0]   rsp_epoch_q, rsp_epoch_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [KEY_W-1:0]     shadow, snapshot;
  logic                 commit_ok, commit_err, pending;
  logic                 accept, rsp_done, defer;

  assign accept   = (state_q == ST_IDLE) && req_valid_i && req_ready_q;
  assign rsp_done = (state_q == ST_RESP) && rsp_valid_q && rsp_ready_i;
  // The handshake edge counts as entry to IDLE, so a commit there lands immediately.
  assign defer    = (state_q != ST_IDLE) && !rsp_done;

  key_scan_chain #(.KEY_W(KEY_W)) u_scan (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .key_sin_i    (key_sin_i),
    .key_shift_i  (key_shift_i),
    .key_commit_i (key_commit_i),
    .defer_i      (defer),
    .apply_i      (rsp_done),
    .commit_ok_o  (commit_ok),
    .commit_err_o (commit_err),
    .pending_o    (pending),
    .shadow_o     (shadow),
    .snapshot_o   (snapshot)
  );

  always_comb begin
    state_d       = state_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    rsp_product_d = rsp_product_q;
    rsp_epoch_d   = rsp_epoch_q;
    key_d         = key_q;
    epoch_d       = epoch_q;
    key_err_d     = commit_err;
    // Handshake flags follow the current state, so each rises one cycle after entry.
    req_ready_d   = (state_q == ST_IDLE) && !accept;
    rsp_valid_d   = (state_q == ST_RESP) && !rsp_done;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        op1_d   = op1_req_i;
        op2_d   = op2_req_i;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        rsp_product_d = product_i;
        rsp_epoch_d   = epoch_q;
        state_d       = ST_RESP;
      end
      ST_RESP: if (rsp_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (commit_ok && !defer) begin
      key_d   = shadow;
      epoch_d = epoch_q + EPOCH_W'(1);
    end else if (rsp_done && pending) begin
      key_d   = snapshot;
      epoch_d = epoch_q + EPOCH_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      key_err_q     <= 1'b0;
      op1_q         <= '0;
      op2_q         <= '0;
      rsp_product_q <= '0;
      rsp_epoch_q   <= '0;
      epoch_q       <= '0;
      key_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      key_err_q     <= key_err_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      rsp_product_q <= rsp_product_d;
      rsp_epoch_q   <= rsp_epoch_d;
      epoch_q       <= epoch_d;
      key_q         <= key_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign key_err_o     = key_err_q;
  assign key_epoch_o   = epoch_q;
  assign op1_o         = op1_q;
  assign op2_o         = op2_q;
  assign keyinput_o    = key_q;
  assign rsp_product_o = rsp_product_q;
  assign rsp_epoch_o   = rsp_epoch_q;
endmodule

// File: tb/tb_locked_mult_key_driver.sv
// Directed bench for locked_mult_key_driver with a behavioural multiplier on product_i.
module tb_locked_mult_key_driver;
  localparam int KEY_W = 32;
  localparam int OP_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              key_sin = 1'b0, key_shift = 1'b0, key_commit = 1'b0;
  logic              key_err;
  logic [3:0]        key_epoch;
  logic              req_valid = 1'b0, req_ready;
  logic [OP_W-1:0]   op1_req = '0, op2_req = '0, op1_o, op2_o;
  logic [KEY_W-1:0]  keyinput;
  logic [2*OP_W-1:0] product, rsp_product;
  logic              rsp_valid, rsp_ready = 1'b0;
  logic [3:0]        rsp_epoch;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign product = {8'h00, op1_o} * {8'h00, op2_o};

  locked_mult_key_driver #(.KEY_W(KEY_W), .OP_W(OP_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .key_sin_i     (key_sin),
    .key_shift_i   (key_shift),
    .key_commit_i  (key_commit),
    .key_err_o     (key_err),
    .key_epoch_o   (key_epoch),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .op1_req_i     (op1_req),
    .op2_req_i     (op2_req),
    .op1_o         (op1_o),
    .op2_o         (op2_o),
    .keyinput_o    (keyinput),
    .product_i     (product),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_product_o (rsp_product),
    .rsp_epoch_o   (rsp_epoch)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_key(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      key_shift = 1'b1;
      key_sin   = v[i];
      tick();
    end
    key_shift = 1'b0;
    key_sin   = 1'b0;
  endtask

  task automatic commit();
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"},   req_ready, 1);
    check_eq({tag, "_rvalid"},  rsp_valid, 0);
    check_eq({tag, "_key"},     keyinput, 0);
    check_eq({tag, "_epoch"},   key_epoch, 0);
    check_eq({tag, "_err"},     key_err, 0);
    check_eq({tag, "_op1"},     op1_o, 0);
    check_eq({tag, "_op2"},     op2_o, 0);
    check_eq({tag, "_product"}, rsp_product, 0);
    check_eq({tag, "_repoch"},  rsp_epoch, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Full key load and commit in IDLE
    shift_key(32'hA5A500FF, 32);
    commit();
    check_eq("load_key", keyinput, 32'hA5A500FF);
    check_eq("load_epoch", key_epoch, 1);
    check_eq("load_err", key_err, 0);

    // Short shift: commit rejected, one-cycle error pulse
    shift_key(32'h12345678, 31);
    commit();
    check_eq("short_err", key_err, 1);
    check_eq("short_key", keyinput, 32'hA5A500FF);
    check_eq("short_epoch", key_epoch, 1);
    tick();
    check_eq("short_err_pulse", key_err, 0);

    // Commit coinciding with a shift is rejected
    shift_key(32'h0, 32);
    key_shift = 1'b1; key_commit = 1'b1;
    tick();
    key_shift = 1'b0; key_commit = 1'b0;
    check_eq("shiftcommit_err", key_err, 1);
    check_eq("shiftcommit_key", keyinput, 32'hA5A500FF);

    // Request 0x0F * 0x11, accepted at this edge (N)
    req_valid = 1'b1; op1_req = 8'h0F; op2_req = 8'h11;
    tick();
    req_valid = 1'b0; op1_req = 8'h00; op2_req = 8'h00;
    check_eq("req_ready_drop", req_ready, 0);
    check_eq("req_op1", op1_o, 8'h0F);
    check_eq("req_op2", op2_o, 8'h11);
    check_eq("rvalid_n0", rsp_valid, 0);
    tick();
    check_eq("rvalid_n1", rsp_valid, 0);
    tick();
    check_eq("rvalid_n2", rsp_valid, 1);
    check_eq("rsp_product", rsp_product, 16'h00FF);
    check_eq("rsp_epoch", rsp_epoch, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("rsp_done_valid", rsp_valid, 0);
    check_eq("idle_ready_lag", req_ready, 0);
    tick();
    check_eq("idle_ready", req_ready, 1);
    check_eq("op1_hold", op1_o, 8'h0F);

    // Commits during a stalled response are deferred until the handshake
    req_valid = 1'b1; op1_req = 8'h20; op2_req = 8'h03;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check_eq("stall_valid", rsp_valid, 1);
    check_eq("stall_product", rsp_product, 16'h0060);
    shift_key(32'h0BADF00D, 32);
    commit();
    check_eq("defer1_key", keyinput, 32'hA5A500FF);
    check_eq("defer1_epoch", key_epoch, 1);
    check_eq("defer1_err", key_err, 0);
    shift_key(32'hCAFEBABE, 32);
    commit();
    check_eq("defer2_key", keyinput, 32'hA5A500FF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_valid", rsp_valid, 1);
      check_eq("hold_product", rsp_product, 16'h0060);
      check_eq("hold_repoch", rsp_epoch, 1);
      check_eq("hold_key", keyinput, 32'hA5A500FF);
      check_eq("hold_epoch", key_epoch, 1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("apply_key", keyinput, 32'hCAFEBABE);
    check_eq("apply_epoch", key_epoch, 2);
    check_eq("apply_valid", rsp_valid, 0);
    tick();
    check_eq("apply_epoch_once", key_epoch, 2);

    // Reset asserted during ISSUE
    req_valid = 1'b1; op1_req = 8'h05; op2_req = 8'h07;
    tick();
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("issue_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset discards a pending commit
    req_valid = 1'b1; op1_req = 8'h02; op2_req = 8'h03;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    shift_key(32'h11111111, 32);
    commit();
    check_eq("pend_key", keyinput, 0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1; op1_req = 8'h04; op2_req = 8'h04;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check_eq("post_rst_valid", rsp_valid, 1);
    check_eq("post_rst_product", rsp_product, 16'h0010);
    check_eq("post_rst_repoch", rsp_epoch, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("discard_key", keyinput, 0);
    check_eq("discard_epoch", key_epoch, 0);

    // Sixteen commits wrap the epoch
    for (int k = 1; k <= 16; k++) begin
      shift_key(32'h01010101 * k, 32);
      commit();
      if (k == 15) check_eq("epoch_15", key_epoch, 15);
    end
    check_eq("epoch_wrap", key_epoch, 0);
    check_eq("wrap_key", keyinput, 32'h10101010);

    // Over-shifting saturates the count; the last 32 bits become the key
    shift_key(32'hFFFFFFFF, 8);
    shift_key(32'h5A5AC3C3, 32);
    commit();
    check_eq("sat_key", keyinput, 32'h5A5AC3C3);
    check_eq("sat_epoch", key_epoch, 1);
    check_eq("sat_err", key_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
